spi_master: RTL and testbench

//  SPI initiator that drives the on-chip SPI memory slave (or any slave using the same frame).

---
 rtl/spi_master.sv | 216 +++++++++++++++++++++
 tb/tb_spi_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------------------------
// spi_master
//   SPI mode-0 initiator. Each transaction is one 16-bit frame: a command byte {addr, rw}
//   followed by one data byte, MSB first. For reads the data byte sent is all zeros and the
//   byte returned on miso is captured into o_rdata at the end of the frame.
//
// Ports
//   i_clk        system clock, all logic on the rising edge
//   i_reset      synchronous active-high reset
//   i_start      transaction request, accepted only while o_busy is low
//   i_rw         1 = read, 0 = write (latched at accept)
//   i_addr       7-bit memory address (latched at accept)
//   i_wdata      write data (latched at accept, ignored for reads)
//   o_busy       high from accept until the inter-frame gap has elapsed
//   o_done       one-cycle pulse coincident with chip select rising
//   o_rdata      last read result; changes only at the done of a read
//   o_sclk_pin   SPI clock, idles low
//   o_cs_pin     chip select, active low
//   o_mosi_pin   serial data out
//   i_miso_pin   serial data in; may be X/Z outside the read data phase
// ---------------------------------------------------------------------------------------------
module spi_master #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_sclk_pin,
    output logic       o_cs_pin,
    output logic       o_mosi_pin,
    input  logic       i_miso_pin
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_t;

    state_t r_state, w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    // r_half: in SHIFT, 0 = sclk-high half, 1 = sclk-low half; in GAP, which half-period.
    logic        r_half,  w_half_next;
    logic [3:0]  r_bit,   w_bit_next;
    logic [15:0] r_shift, w_shift_next;
    logic        r_rw,    w_rw_next;
    logic [7:0]  r_rx,    w_rx_next;
    logic        r_sclk,  w_sclk_next;
    logic        r_cs,    w_cs_next;
    logic        r_mosi,  w_mosi_next;
    logic        r_busy,  w_busy_next;
    logic        r_done,  w_done_next;
    logic [7:0]  r_rdata, w_rdata_next;

    assign w_tc = (r_cnt == CNT_MAX);

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_half  <= 1'b0;
            r_bit   <= 4'd0;
            r_shift <= 16'h0000;
            r_rw    <= 1'b0;
            r_rx    <= 8'h00;
            r_sclk  <= 1'b0;
            r_cs    <= 1'b1;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_state <= w_state_next;
            // Half-period counter only runs outside IDLE so SETUP starts from zero.
            if (r_state == StIdle) begin
                r_cnt <= '0;
            end else if (w_tc) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_half  <= w_half_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_rw    <= w_rw_next;
            r_rx    <= w_rx_next;
            r_sclk  <= w_sclk_next;
            r_cs    <= w_cs_next;
            r_mosi  <= w_mosi_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_rdata <= w_rdata_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_start)                          w_state_next = StSetup;
            StSetup: if (w_tc)                             w_state_next = StShift;
            StShift: if (w_tc && r_half && r_bit == 4'd15) w_state_next = StHold;
            StHold:  if (w_tc)                             w_state_next = StGap;
            StGap:   if (w_tc && r_half)                   w_state_next = StIdle;
            default:                                       w_state_next = StIdle;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_half_next  = r_half;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_rw_next    = r_rw;
        w_rx_next    = r_rx;
        w_sclk_next  = r_sclk;
        w_cs_next    = r_cs;
        w_mosi_next  = r_mosi;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_rdata_next = r_rdata;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_rw_next    = i_rw;
                    w_shift_next = {i_addr, i_rw, (i_rw ? 8'h00 : i_wdata)};
                    w_mosi_next  = i_addr[6];
                    w_cs_next    = 1'b0;
                    w_busy_next  = 1'b1;
                    w_half_next  = 1'b0;
                    w_bit_next   = 4'd0;
                end
            end
            StSetup: begin
                if (w_tc) begin
                    w_sclk_next = 1'b1;
                    w_half_next = 1'b0;
                end
            end
            StShift: begin
                if (w_tc) begin
                    if (!r_half) begin
                        // Falling sclk: advance mosi, capture miso during read data bits.
                        w_sclk_next = 1'b0;
                        w_half_next = 1'b1;
                        if (r_bit == 4'd15) begin
                            w_mosi_next = 1'b0;
                        end else begin
                            w_mosi_next  = r_shift[14];
                            w_shift_next = {r_shift[14:0], 1'b0};
                        end
                        // Gating keeps X/Z on miso out of rx outside the read data phase.
                        if (r_rw && r_bit[3]) begin
                            w_rx_next = {r_rx[6:0], i_miso_pin};
                        end
                    end else begin
                        w_half_next = 1'b0;
                        if (r_bit != 4'd15) begin
                            w_bit_next  = r_bit + 4'd1;
                            w_sclk_next = 1'b1;
                        end
                    end
                end
            end
            StHold: begin
                if (w_tc) begin
                    w_cs_next   = 1'b1;
                    w_done_next = 1'b1;
                    w_half_next = 1'b0;
                    if (r_rw) begin
                        w_rdata_next = r_rx;
                    end
                end
            end
            StGap: begin
                if (w_tc) begin
                    if (!r_half) begin
                        w_half_next = 1'b1;
                    end else begin
                        w_half_next = 1'b0;
                        w_busy_next = 1'b0;
                    end
                end
            end
            default: begin
                w_cs_next   = 1'b1;
                w_sclk_next = 1'b0;
                w_busy_next = 1'b0;
            end
        endcase
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_rdata    = r_rdata;
    assign o_sclk_pin = r_sclk;
    assign o_cs_pin   = r_cs;
    assign o_mosi_pin = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------------------------
// tb_spi_master
//   Directed bench for spi_master with a behavioural SPI memory slave. Expected frames and
//   read data are queued when a transaction is issued; a monitor pops and checks at each done.
// ---------------------------------------------------------------------------------------------
module tb_spi_master;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;

    always #5 clk = ~clk;

    spi_master #(
        .CLK_DIV(DIV)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_rw       (rw),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .o_busy     (busy),
        .o_done     (done),
        .o_rdata    (rdata),
        .o_sclk_pin (sclk),
        .o_cs_pin   (cs),
        .o_mosi_pin (mosi),
        .i_miso_pin (miso)
    );

    typedef struct packed {
        logic [15:0] frame;
        logic [7:0]  rdata;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // ---------------- behavioural SPI memory slave (sampled on clk falling edge) -------------
    logic [7:0]  mem [128];
    logic [15:0] s_frame = 16'h0000;
    int          s_cnt   = 0;
    logic        s_rd    = 1'b0;
    logic [6:0]  s_addr  = 7'h00;
    logic        p_cs    = 1'b1;
    logic        p_sclk  = 1'b0;
    bit          seeded  = 1'b0;

    always @(negedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 128; i++) mem[i] = 8'h00;
            mem[5] = 8'h3C;
            miso   = 1'bx;
            seeded = 1'b1;
        end
        if (p_cs && !cs) begin
            s_cnt   = 0;
            s_frame = 16'h0000;
        end
        if (!cs && !p_sclk && sclk) begin
            s_frame = {s_frame[14:0], mosi};
            s_cnt++;
        end
        if (!cs && p_sclk && !sclk) begin
            if (s_cnt == 8) begin
                s_rd   = s_frame[0];
                s_addr = s_frame[7:1];
            end
            if (s_cnt >= 8 && s_cnt <= 15 && s_rd) miso = mem[s_addr][15-s_cnt];
            else miso = 1'bx;
        end
        if (!p_cs && cs) begin
            if (s_cnt == 16 && !s_frame[8]) mem[s_frame[15:9]] = s_frame[7:0];
            miso = 1'bx;
        end
        p_cs   = cs;
        p_sclk = sclk;
    end

    // ---------------- monitor / scoreboard ---------------------------------------------------
    int   cyc      = 0;
    int   fall_cyc = 0;
    int   rise_cyc = 0;
    int   done_cyc = 0;
    int   gap_len  = 0;
    int   n_done   = 0;
    logic m_cs     = 1'b1;
    logic m_busy   = 1'b0;
    logic m_done   = 1'b0;
    bit   wait_bf  = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            wait_bf = 1'b0;
        end else begin
            if (m_cs && !cs) begin
                fall_cyc = cyc;
                gap_len  = cyc - rise_cyc;
            end
            if (!m_cs && cs) rise_cyc = cyc;
            if (done) begin
                n_done++;
                check("done_width", {31'd0, m_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got a done pulse, want none");
                end else begin
                    e = exp_q.pop_front();
                    check("frame_bits", {16'd0, s_frame}, {16'd0, e.frame});
                    check("sclk_rises", s_cnt, 16);
                    check("done_latency", cyc - fall_cyc, 34 * DIV);
                    check("cs_high_at_done", {31'd0, cs}, 32'd1);
                    check("rdata", {24'd0, rdata}, {24'd0, e.rdata});
                end
                done_cyc = cyc;
                wait_bf  = 1'b1;
            end
            if (wait_bf && m_busy && !busy) begin
                check("busy_fall", cyc - done_cyc, 2 * DIV);
                wait_bf = 1'b0;
            end
        end
        m_cs   = cs;
        m_busy = busy;
        m_done = done;
    end

    // ---------------- stimulus ----------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_busy(input logic v, input string name);
        int n = 0;
        @(negedge clk);
        while (busy !== v && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, busy}, {31'd0, v});
    endtask

    task automatic wait_bits(input int k, input string name);
        int n = 0;
        tick(2);
        while (s_cnt < k && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, (s_cnt >= k)}, 32'd1);
    endtask

    task automatic push_exp(input logic [15:0] ef, input logic [7:0] er);
        exp_t t;
        t.frame = ef;
        t.rdata = er;
        exp_q.push_back(t);
    endtask

    // Called at a falling clk edge; scrambles inputs after accept to show they are ignored.
    task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d,
                         input logic [15:0] ef, input logic [7:0] er, input bit push);
        rw    = r;
        addr  = a;
        wdata = d;
        start = 1'b1;
        if (push) push_exp(ef, er);
        wait_busy(1'b1, "accept");
        start = 1'b0;
        rw    = ~r;
        addr  = ~a;
        wdata = ~d;
    endtask

    int nd0;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        rw    = 1'b0;
        addr  = 7'h00;
        wdata = 8'h00;

        // T1: reset with a start pulse inside it
        @(negedge clk);
        start = 1'b1;
        addr  = 7'h11;
        wdata = 8'h22;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_cs", {31'd0, cs}, 32'd1);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        reset = 1'b0;
        tick(6);
        check("t1_no_frame_busy", {31'd0, busy}, 32'd0);
        check("t1_no_frame_cs", {31'd0, cs}, 32'd1);

        // T2: write 0x2A <- 0xA5
        issue(1'b0, 7'h2A, 8'hA5, 16'h54A5, 8'h00, 1'b1);
        wait_busy(1'b0, "t2_idle");

        // T3: read 0x05 (slave holds 0x3C), then a write must leave rdata alone
        issue(1'b1, 7'h05, 8'h5A, 16'h0B00, 8'h3C, 1'b1);
        wait_busy(1'b0, "t3_idle");
        issue(1'b0, 7'h10, 8'h77, 16'h2077, 8'h3C, 1'b1);
        wait_busy(1'b0, "t3w_idle");

        // T4: start pulse during bit 9 with new operands is ignored
        nd0 = n_done;
        issue(1'b0, 7'h33, 8'hC3, 16'h66C3, 8'h3C, 1'b1);
        wait_bits(10, "t4_reach_bit9");
        start = 1'b1;
        rw    = 1'b1;
        addr  = 7'h01;
        wdata = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_busy(1'b0, "t4_idle");
        tick(3);
        check("t4_one_done", n_done - nd0, 1);

        // T5: reset at the 5th sclk rising edge aborts the frame
        nd0 = n_done;
        issue(1'b0, 7'h44, 8'h99, 16'h0000, 8'h00, 1'b0);
        wait_bits(5, "t5_reach_rise5");
        reset = 1'b1;
        @(negedge clk);
        check("t5_cs", {31'd0, cs}, 32'd1);
        check("t5_sclk", {31'd0, sclk}, 32'd0);
        check("t5_mosi", {31'd0, mosi}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_rdata", {24'd0, rdata}, 32'd0);
        reset = 1'b0;
        tick(40 * DIV);
        check("t5_no_done", n_done - nd0, 0);
        issue(1'b1, 7'h05, 8'h00, 16'h0B00, 8'h3C, 1'b1);
        wait_busy(1'b0, "t5_idle");

        // T6: memory round trip at the address extremes
        issue(1'b0, 7'h7F, 8'h11, 16'hFE11, 8'h3C, 1'b1);
        wait_busy(1'b0, "t6_w1_idle");
        issue(1'b0, 7'h00, 8'hEE, 16'h00EE, 8'h3C, 1'b1);
        wait_busy(1'b0, "t6_w2_idle");
        // Back-to-back reads with start held high
        rw    = 1'b1;
        addr  = 7'h7F;
        wdata = 8'h00;
        start = 1'b1;
        push_exp(16'hFF00, 8'h11);
        wait_busy(1'b1, "t6_r1_accept");
        addr = 7'h00;
        push_exp(16'h0100, 8'hEE);
        wait_busy(1'b0, "t6_r1_end");
        wait_busy(1'b1, "t6_r2_accept");
        start = 1'b0;
        addr  = 7'h55;
        tick(2);
        check("t6_cs_gap", gap_len, 2 * DIV + 1);
        wait_busy(1'b0, "t6_r2_idle");

        tick(5);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
